switch_debouncer: RTL and testbench



---
 rtl/switch_debouncer.sv | 124 ++++++++++++
 tb/tb_switch_debouncer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Per-channel synchronizer and debouncer: clean level outputs plus one-cycle
// rise/fall strobes once a new level has been held for STABLE_CYCLES samples.
module switch_debouncer #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1250000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        CHK_HIGH = 2'd1,
        HIGH     = 2'd2,
        CHK_LOW  = 2'd3
    } state_e;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_e                 state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   out_q, out_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;

        // Only the first stage may go metastable; the last stage is the clean sample.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw[i]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q <= LOW;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        // Any sample disagreeing with the candidate level restarts qualification.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            out_d   = out_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
                LOW: begin
                    if (s) begin
                        state_d = CHK_HIGH;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                CHK_HIGH: begin
                    if (!s) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = HIGH;
                        out_d   = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state_d = CHK_LOW;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                CHK_LOW: begin
                    if (s) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = LOW;
                        out_d   = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = LOW;
                    cnt_d   = '0;
                end
            endcase
        end

        assign sw_out[i] = out_q;
        assign rise[i]   = rise_q;
        assign fall[i]   = fall_q;
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: a run-length reference model predicts
// each cycle's outputs, plus directed latency/strobe checks per scenario.
module tb_switch_debouncer;

    localparam int unsigned W      = 2;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned STABLE = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_out, rise, fall;

    int n_checks = 0;
    int n_pass   = 0;

    logic [5:0] sb[$];

    // reference model state
    logic [1:0] msync[2];
    logic [1:0] out_m;
    int         run_m[2];

    switch_debouncer #(
        .WIDTH(W),
        .SYNC_STAGES(SYNC),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .sw_raw(sw_raw),
        .sw_out(sw_out),
        .rise(rise),
        .fall(fall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        msync[0] = 2'b00;
        msync[1] = 2'b00;
        out_m    = 2'b00;
        run_m[0] = 0;
        run_m[1] = 0;
        sb.delete();
    endtask

    // Level flips after STABLE consecutive samples differing from the current level.
    task automatic model_edge(input logic [1:0] raw);
        logic [1:0] r, f;
        r = 2'b00;
        f = 2'b00;
        for (int c = 0; c < 2; c++) begin
            if (msync[c][1] != out_m[c]) begin
                run_m[c]++;
                if (run_m[c] == STABLE) begin
                    out_m[c] = ~out_m[c];
                    if (out_m[c]) r[c] = 1'b1;
                    else          f[c] = 1'b1;
                    run_m[c] = 0;
                end
            end else begin
                run_m[c] = 0;
            end
            msync[c] = {msync[c][0], raw[c]};
        end
        sb.push_back({out_m, r, f});
    endtask

    task automatic step(input logic [1:0] raw);
        logic [5:0] exp;
        sw_raw = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'(1), 32'(0));
        end else begin
            exp = sb.pop_front();
            check("sb", 32'({sw_out, rise, fall}), 32'(exp));
        end
    endtask

    task automatic measure(input logic [1:0] raw, input int n,
                           output int first_chg, output logic [1:0] out_at,
                           output logic [1:0] rise_at, output logic [1:0] fall_at,
                           output int nr0, output int nf0, output logic [1:0] any_strobe);
        logic [1:0] start;
        start      = sw_out;
        first_chg  = 0;
        out_at     = 2'b00;
        rise_at    = 2'b00;
        fall_at    = 2'b00;
        nr0        = 0;
        nf0        = 0;
        any_strobe = 2'b00;
        for (int k = 1; k <= n; k++) begin
            step(raw);
            if (first_chg == 0 && sw_out != start) begin
                first_chg = k;
                out_at    = sw_out;
                rise_at   = rise;
                fall_at   = fall;
            end
            nr0        += int'(rise[0]);
            nf0        += int'(fall[0]);
            any_strobe |= rise | fall;
        end
    endtask

    int         fc, nr0, nf0;
    logic [1:0] out_at, rise_at, fall_at, strb, acc;

    initial begin
        resetn = 1'b1;
        sw_raw = 2'b11;
        model_reset();
        #2 resetn = 1'b0;
        #1;
        check("rst_async", 32'({sw_out, rise, fall}), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", 32'({sw_out, rise, fall}), 32'(0));

        // Switches high at reset release qualify as a press
        resetn = 1'b1;
        measure(2'b11, 10, fc, out_at, rise_at, fall_at, nr0, nf0, strb);
        check("rst_lat", 32'(fc), 32'(6));
        check("rst_out", 32'(out_at), 32'(2'b11));
        check("rst_rise", 32'(rise_at), 32'(2'b11));
        check("rst_nrise", 32'(nr0), 32'(1));
        check("rst_nfall", 32'(nf0), 32'(0));
        check("rst_rise_off", 32'(rise), 32'(0));

        // Clean step on channel 0 with channel 1 held high
        measure(2'b10, 10, fc, out_at, rise_at, fall_at, nr0, nf0, strb);
        check("pre_out", 32'(sw_out), 32'(2'b10));
        measure(2'b11, 10, fc, out_at, rise_at, fall_at, nr0, nf0, strb);
        check("up_lat", 32'(fc), 32'(6));
        check("up_out", 32'(out_at), 32'(2'b11));
        check("up_rise", 32'(rise_at), 32'(2'b01));
        check("up_nrise", 32'(nr0), 32'(1));
        check("up_strb", 32'(strb), 32'(2'b01));
        measure(2'b10, 10, fc, out_at, rise_at, fall_at, nr0, nf0, strb);
        check("dn_lat", 32'(fc), 32'(6));
        check("dn_out", 32'(out_at), 32'(2'b10));
        check("dn_fall", 32'(fall_at), 32'(2'b01));
        check("dn_nfall", 32'(nf0), 32'(1));
        check("dn_nrise", 32'(nr0), 32'(0));

        // Bounce: 1,1,1,0 then hold 1
        acc = 2'b00;
        step(2'b11); acc |= rise | fall;
        step(2'b11); acc |= rise | fall;
        step(2'b11); acc |= rise | fall;
        step(2'b10); acc |= rise | fall;
        measure(2'b11, 10, fc, out_at, rise_at, fall_at, nr0, nf0, strb);
        acc |= (fc < 6) ? 2'b11 : 2'b00;
        check("bnc_quiet", 32'(acc), 32'(0));
        check("bnc_lat", 32'(fc), 32'(6));
        check("bnc_nrise", 32'(nr0), 32'(1));
        check("bnc_out", 32'(sw_out), 32'(2'b11));

        // Glitch: 3 high cycles then low
        measure(2'b10, 10, fc, out_at, rise_at, fall_at, nr0, nf0, strb);
        check("gl_pre", 32'(sw_out), 32'(2'b10));
        acc = 2'b00;
        for (int k = 0; k < 3; k++) begin
            step(2'b11);
            acc |= rise | fall;
        end
        measure(2'b10, 22, fc, out_at, rise_at, fall_at, nr0, nf0, strb);
        check("gl_strb", 32'(acc | strb), 32'(0));
        check("gl_chg", 32'(fc), 32'(0));
        check("gl_out", 32'(sw_out), 32'(2'b10));

        // Simultaneous opposite transitions on both channels
        measure(2'b01, 10, fc, out_at, rise_at, fall_at, nr0, nf0, strb);
        check("sim_pre", 32'(sw_out), 32'(2'b01));
        measure(2'b10, 8, fc, out_at, rise_at, fall_at, nr0, nf0, strb);
        check("sim_lat", 32'(fc), 32'(6));
        check("sim_out", 32'(out_at), 32'(2'b10));
        check("sim_rise", 32'(rise_at), 32'(2'b10));
        check("sim_fall", 32'(fall_at), 32'(2'b01));

        // Reset in the middle of a rising qualification
        measure(2'b00, 12, fc, out_at, rise_at, fall_at, nr0, nf0, strb);
        check("rm_pre", 32'(sw_out), 32'(2'b00));
        for (int k = 0; k < 4; k++) step(2'b01);
        resetn = 1'b0;
        model_reset();
        #1;
        check("rm_async", 32'({sw_out, rise, fall}), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        measure(2'b01, 10, fc, out_at, rise_at, fall_at, nr0, nf0, strb);
        check("rm_lat", 32'(fc), 32'(6));
        check("rm_rise", 32'(rise_at), 32'(2'b01));
        check("rm_nrise", 32'(nr0), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
